// File: rtl/mips_instruction_category_queue_pkg.sv
// mips_instruction_category_pkg: category indices, opfunc source encoding and counter select constants
package mips_instruction_category_pkg;
  localparam int CATEGORY_WIDTH = 15;
  localparam int CAT_REGISTER = 0;
  localparam int CAT_IMMEDIATE = 1;
  localparam int CAT_JUMP = 2;
  localparam int CAT_BRANCH = 3;
  localparam int CAT_LINK = 4;
  localparam int CAT_SHIFT = 5;
  localparam int CAT_SHIFT_V = 6;
  localparam int CAT_HILO = 7;
  localparam int CAT_MUL_DIV = 8;
  localparam int CAT_COMPARE = 9;
  localparam int CAT_LOGIC = 10;
  localparam int CAT_ARITHMETIC = 11;
  localparam int CAT_LOAD = 12;
  localparam int CAT_STORE = 13;
  localparam int CAT_UNKNOWN = 14;
  localparam int COUNT_SELECT_TOTAL = 15;
  typedef enum logic {SRC_FUNC = 1'b0, SRC_OP = 1'b1} opfunc_src_t;
endpackage

// File: rtl/mips_instruction_category_queue_if.sv
// mips_instruction_category_queue_if: enqueue and dequeue handshake bundle
interface mips_instruction_category_queue_if #(parameter int TAG_WIDTH = 32);
  import mips_instruction_category_pkg::*;
  logic in_valid;
  logic in_ready;
  logic [31:0] in_instr;
  logic [TAG_WIDTH-1:0] in_tag;
  logic out_valid;
  logic out_ready;
  logic [31:0] out_instr;
  logic [TAG_WIDTH-1:0] out_tag;
  logic [CATEGORY_WIDTH-1:0] out_category;
  modport master (output in_valid, in_instr, in_tag, out_ready,
                  input in_ready, out_valid, out_instr, out_tag, out_category);
  modport slave (input in_valid, in_instr, in_tag, out_ready,
                 output in_ready, out_valid, out_instr, out_tag, out_category);
endinterface

// File: rtl/mips_instruction_category_decode.sv
// mips_instruction_category_decode: combinational MIPS instruction word to category vector
module mips_instruction_category_decode
  import mips_instruction_category_pkg::*;
(
  input  logic [31:0] instr,
  output logic [CATEGORY_WIDTH-1:0] category
);
  opfunc_src_t src;
  logic [5:0] code;
  logic f, o;
  logic unused_bits;
  assign unused_bits = ^{instr[25:21], instr[19:6]};
  assign src = (instr[31:26] == 6'd0) ? SRC_FUNC : SRC_OP;
  assign code = (src == SRC_FUNC) ? instr[5:0] : instr[31:26];
  assign f = src == SRC_FUNC;
  assign o = src == SRC_OP;
  // Each category is a pattern match on the unified opfunc code
  always_comb begin
    category = '0;
    category[CAT_REGISTER] = f;
    category[CAT_IMMEDIATE] = o;
    category[CAT_JUMP] = (f && code[5:3] == 3'b001) || (o && code[5:1] == 5'b00001);
    category[CAT_BRANCH] = o && (code == 6'b000001 || code[5:2] == 4'b0001);
    category[CAT_LINK] = (o && code == 6'b000011) || (f && code == 6'b001001) || (o && code == 6'b000001 && instr[20]);
    category[CAT_SHIFT] = f && code[5:3] == 3'b000;
    category[CAT_SHIFT_V] = f && code[5:2] == 4'b0001;
    category[CAT_HILO] = f && code[5:3] == 3'b010;
    category[CAT_MUL_DIV] = f && code[5:3] == 3'b011;
    category[CAT_COMPARE] = (f && code[5:3] == 3'b101) || (o && code[5:1] == 5'b00101);
    category[CAT_LOGIC] = (f && code[5:2] == 4'b1001) || (o && code[5:2] == 4'b0011);
    category[CAT_ARITHMETIC] = (f && code[5:2] == 4'b1000) || (o && code[5:1] == 5'b00100);
    category[CAT_LOAD] = o && code[5:3] == 3'b100;
    category[CAT_STORE] = o && code[5:3] == 3'b101;
    category[CAT_UNKNOWN] = ~|category[CAT_STORE:CAT_JUMP];
  end
endmodule

// File: rtl/mips_instruction_category_queue.sv
// mips_instruction_category_queue: decode-at-enqueue FIFO with saturating per-category retire counters
module mips_instruction_category_queue
  import mips_instruction_category_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_WIDTH = 32,
  parameter int COUNT_WIDTH = 16
) (
  input  logic clock,
  input  logic reset,
  mips_instruction_category_queue_if.slave bus,
  input  logic flush,
  output logic [$clog2(DEPTH):0] occupancy,
  input  logic [3:0] count_select,
  output logic [COUNT_WIDTH-1:0] count_value,
  input  logic count_clear
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_ptr, rd_ptr;
  logic [31:0] instr_mem [DEPTH];
  logic [TAG_WIDTH-1:0] tag_mem [DEPTH];
  logic [CATEGORY_WIDTH-1:0] cat_mem [DEPTH];
  logic [CATEGORY_WIDTH-1:0] in_category;
  logic [CATEGORY_WIDTH:0] hits;
  logic [COUNT_WIDTH-1:0] counts [COUNT_SELECT_TOTAL+1];
  logic empty, push, pop;
  mips_instruction_category_decode u_decode (.instr(bus.in_instr), .category(in_category));
  assign empty = wr_ptr == rd_ptr;
  assign occupancy = wr_ptr - rd_ptr;
  assign bus.in_ready = !occupancy[AW];
  assign bus.out_valid = !empty;
  assign push = bus.in_valid && bus.in_ready && !flush;
  assign pop = bus.out_valid && bus.out_ready && !flush;
  assign bus.out_instr = empty ? '0 : instr_mem[rd_ptr[AW-1:0]];
  assign bus.out_tag = empty ? '0 : tag_mem[rd_ptr[AW-1:0]];
  assign bus.out_category = empty ? '0 : cat_mem[rd_ptr[AW-1:0]];
  assign hits = {1'b1, bus.out_category};
  assign count_value = counts[count_select];
  // Pointers carry an extra wrap bit so full and empty differ; flush rewinds both
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end
  // Entry storage, written with its category decoded at enqueue
  always_ff @(posedge clock) begin
    if (push) begin
      instr_mem[wr_ptr[AW-1:0]] <= bus.in_instr;
      tag_mem[wr_ptr[AW-1:0]] <= bus.in_tag;
      cat_mem[wr_ptr[AW-1:0]] <= in_category;
    end
  end
  // Retire counters: one per category plus a total, saturating, clear wins
  always_ff @(posedge clock) begin
    for (int i = 0; i <= COUNT_SELECT_TOTAL; i++)
      if (reset || count_clear) counts[i] <= '0;
      else if (pop && hits[i] && counts[i] != '1) counts[i] <= counts[i] + 1'b1;
  end
endmodule

// File: tb/tb_mips_instruction_category_queue.sv
// tb_mips_instruction_category_queue: directed and random checks against a queue-based reference model
module tb_mips_instruction_category_queue;
  localparam int DEPTH = 4;
  localparam int CW = 4;
  localparam int SAT = (1 << CW) - 1;
  typedef struct {
    logic [31:0] instr;
    logic [31:0] tag;
    logic [14:0] cat;
  } entry_t;
  logic clk = 0;
  logic rst = 1;
  logic flush = 0;
  logic count_clear = 0;
  logic [3:0] count_select = 0;
  logic [2:0] occupancy;
  logic [CW-1:0] count_value;
  int vectors = 0;
  int miscompares = 0;
  entry_t mq[$];
  int cnt[16];
  mips_instruction_category_queue_if #(.TAG_WIDTH(32)) bus ();
  mips_instruction_category_queue #(.DEPTH(DEPTH), .TAG_WIDTH(32), .COUNT_WIDTH(CW)) dut (
    .clock(clk), .reset(rst), .bus(bus), .flush(flush), .occupancy(occupancy),
    .count_select(count_select), .count_value(count_value), .count_clear(count_clear));
  always #5 clk = ~clk;

  function automatic logic [14:0] ref_cat(input logic [31:0] w);
    logic [5:0] op, fn;
    logic [14:0] c;
    op = w[31:26];
    fn = w[5:0];
    c = '0;
    if (op == 6'd0) begin
      c[0] = 1;
      casez (fn)
        6'b000???: begin c[5] = 1; c[6] = fn[2]; end
        6'b001???: begin c[2] = 1; c[4] = (fn == 6'b001001); end
        6'b010???: c[7] = 1;
        6'b011???: c[8] = 1;
        6'b1000??: c[11] = 1;
        6'b1001??: c[10] = 1;
        6'b101???: c[9] = 1;
        default: ;
      endcase
    end else begin
      c[1] = 1;
      casez (op)
        6'b000001: begin c[3] = 1; c[4] = w[20]; end
        6'b00001?: begin c[2] = 1; c[4] = op[0]; end
        6'b0001??: c[3] = 1;
        6'b00100?: c[11] = 1;
        6'b00101?: c[9] = 1;
        6'b0011??: c[10] = 1;
        6'b100???: c[12] = 1;
        6'b101???: c[13] = 1;
        default: ;
      endcase
    end
    c[14] = (c[13:2] == 12'd0);
    return c;
  endfunction

  task automatic chk(input string t, input logic [63:0] o, input logic [63:0] e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", t, o, e);
    end
  endtask

  task automatic cycle(input bit r, input bit v, input logic [31:0] ins, input logic [31:0] tg,
                       input bit ordy, input bit fl, input bit clr, input logic [3:0] sel);
    bit do_push, do_pop;
    entry_t h;
    @(negedge clk);
    rst = r; bus.in_valid = v; bus.in_instr = ins; bus.in_tag = tg;
    bus.out_ready = ordy; flush = fl; count_clear = clr; count_select = sel;
    #1;
    chk("out_valid", 64'(bus.out_valid), 64'(mq.size() > 0));
    chk("in_ready", 64'(bus.in_ready), 64'(mq.size() < DEPTH));
    chk("occupancy", 64'(occupancy), 64'(mq.size()));
    chk("out_instr", 64'(bus.out_instr), mq.size() ? 64'(mq[0].instr) : 64'd0);
    chk("out_tag", 64'(bus.out_tag), mq.size() ? 64'(mq[0].tag) : 64'd0);
    chk("out_category", 64'(bus.out_category), mq.size() ? 64'(mq[0].cat) : 64'd0);
    chk("count_value", 64'(count_value), 64'(cnt[sel]));
    do_push = v && mq.size() < DEPTH && !fl;
    do_pop = ordy && mq.size() > 0 && !fl;
    @(posedge clk);
    if (r) begin
      mq.delete();
      foreach (cnt[i]) cnt[i] = 0;
    end else begin
      if (do_pop) begin
        h = mq.pop_front();
        if (!clr) begin
          for (int i = 0; i < 15; i++) if (h.cat[i] && cnt[i] < SAT) cnt[i]++;
          if (cnt[15] < SAT) cnt[15]++;
        end
      end
      if (clr) foreach (cnt[i]) cnt[i] = 0;
      if (fl) mq.delete();
      if (do_push) mq.push_back('{ins, tg, ref_cat(ins)});
    end
  endtask

  task automatic idle(input logic [3:0] sel);
    cycle(0, 0, 32'd0, 32'd0, 0, 0, 0, sel);
  endtask

  logic [31:0] pool [12] = '{32'h24020005, 32'h04110003, 32'h04000003, 32'h0060F809, 32'hFC000000,
                             32'h8C820000, 32'hAC820000, 32'h00851021, 32'h0C000010, 32'h00000000,
                             32'h00430018, 32'h3C011000};

  initial begin
    bus.in_valid = 0; bus.in_instr = 0; bus.in_tag = 0; bus.out_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 0);
    chk("rst_in_ready", 64'(bus.in_ready), 1);
    chk("rst_occupancy", 64'(occupancy), 0);
    chk("rst_count", 64'(count_value), 0);
    chk("rst_out_instr", 64'(bus.out_instr), 0);
    // addiu enqueued while empty
    cycle(0, 1, 32'h24020005, 32'h400, 0, 0, 0, 0);
    #1;
    chk("addiu_valid", 64'(bus.out_valid), 1);
    chk("addiu_cat", 64'(bus.out_category), 64'h0802);
    chk("addiu_tag", 64'(bus.out_tag), 64'h400);
    cycle(0, 0, 0, 0, 1, 0, 0, 0);
    // bgezal then bltz
    cycle(0, 1, 32'h04110003, 32'h404, 0, 0, 0, 0);
    cycle(0, 1, 32'h04000003, 32'h408, 0, 0, 0, 0);
    #1;
    chk("bgezal_cat", 64'(bus.out_category), 64'h001A);
    cycle(0, 0, 0, 0, 1, 0, 0, 0);
    #1;
    chk("bltz_cat", 64'(bus.out_category), 64'h000A);
    cycle(0, 0, 0, 0, 1, 0, 0, 0);
    // jalr then unknown opcode
    cycle(0, 1, 32'h0060F809, 32'h40C, 0, 0, 0, 0);
    cycle(0, 1, 32'hFC000000, 32'h410, 0, 0, 0, 0);
    #1;
    chk("jalr_cat", 64'(bus.out_category), 64'h0015);
    cycle(0, 0, 0, 0, 1, 0, 0, 0);
    #1;
    chk("op3f_cat", 64'(bus.out_category), 64'h4002);
    cycle(0, 0, 0, 0, 1, 0, 0, 0);
    // fill to full, then stream across the pointer wrap
    for (int i = 0; i < 5; i++) cycle(0, 1, pool[i], 32'h500 + i, 0, 0, 0, 15);
    #1;
    chk("full_occupancy", 64'(occupancy), 4);
    chk("full_in_ready", 64'(bus.in_ready), 0);
    for (int i = 0; i < 6; i++) cycle(0, 1, pool[i + 5], 32'h600 + i, 1, 0, 0, 15);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 1, 0, 0, 15);
    // flush with in_valid and out_ready asserted
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, pool[i], 32'h700 + i, 0, 0, 0, 0);
    cycle(0, 1, 32'h24020005, 32'h7FF, 1, 1, 0, 15);
    #1;
    chk("flush_occupancy", 64'(occupancy), 0);
    chk("flush_out_valid", 64'(bus.out_valid), 0);
    idle(15);
    chk("flush_total", 64'(count_value), 0);
    // saturation with lw
    for (int i = 0; i < 21; i++) cycle(0, 1, 32'h8C820000, 32'h800 + i, i > 0, 0, 0, 12);
    cycle(0, 0, 0, 0, 1, 0, 0, 12);
    idle(12);
    chk("sat_load", 64'(count_value), SAT);
    idle(15);
    chk("sat_total", 64'(count_value), SAT);
    cycle(0, 1, 32'h8C820000, 32'h900, 0, 0, 0, 15);
    cycle(0, 0, 0, 0, 1, 0, 1, 15);
    idle(15);
    chk("clear_total", 64'(count_value), 0);
    idle(12);
    chk("clear_load", 64'(count_value), 0);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] w;
      w = ($urandom_range(3) == 0) ? $urandom : pool[$urandom_range(11)];
      cycle($urandom_range(99) == 0, $urandom_range(2) != 0, w, $urandom, $urandom_range(2) != 0,
            $urandom_range(19) == 0, $urandom_range(29) == 0, 4'($urandom_range(15)));
    end
    // reset mid-operation
    cycle(0, 1, pool[0], 32'hA00, 0, 0, 0, 15);
    cycle(0, 1, pool[1], 32'hA04, 0, 0, 0, 15);
    cycle(1, 1, pool[2], 32'hA08, 1, 0, 0, 15);
    #1;
    chk("midrst_occupancy", 64'(occupancy), 0);
    chk("midrst_out_valid", 64'(bus.out_valid), 0);
    chk("midrst_total", 64'(count_value), 0);
    idle(0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
